// File: rtl/code_lock_if.sv
// code_lock_if
//   Groups the keypad/lock signals of code_lock_fsm into one bundle.
//   master : drives din, din_valid, key, lock_cmd; observes status.
//   slave  : the lock itself; consumes inputs, drives status.
//   Signals:
//     din       - entered 2-bit digit {A1,A0}
//     din_valid - din is sampled this cycle
//     key       - stored code, digit n = key[2n+1:2n]
//     lock_cmd  - relock request (honoured only while open)
//     unlocked  - lock is in OPEN
//     alarm     - lock is in ALARM
//     fails     - failed-entry count
//     idx       - index of the next expected digit
interface code_lock_if;
  logic [1:0] din;
  logic       din_valid;
  logic [7:0] key;
  logic       lock_cmd;
  logic       unlocked;
  logic       alarm;
  logic [1:0] fails;
  logic [1:0] idx;

  modport master (
    output din, din_valid, key, lock_cmd,
    input  unlocked, alarm, fails, idx
  );

  modport slave (
    input  din, din_valid, key, lock_cmd,
    output unlocked, alarm, fails, idx
  );
endinterface

// File: rtl/code_lock_fsm.sv
// code_lock_fsm
//   Four-digit combination lock. Digits arrive on bus.din qualified by
//   bus.din_valid and are compared against bus.key one at a time. A full
//   correct entry opens the lock; MAX_FAILS wrong entries latch the alarm,
//   which only rst clears. A partial entry left idle for TIMEOUT cycles is
//   discarded without counting as a failure. All outputs are registered.
//   Ports:
//     clk - single clock, rising edge
//     rst - synchronous, active-high reset
//     bus - code_lock_if slave (din, din_valid, key, lock_cmd in;
//           unlocked, alarm, fails, idx out)
module code_lock_fsm #(
  parameter int TIMEOUT   = 15,
  parameter int MAX_FAILS = 3
) (
  input logic        clk,
  input logic        rst,
  code_lock_if.slave bus
);

  typedef enum logic [1:0] {
    ST_ENTRY = 2'd0,
    ST_OPEN  = 2'd1,
    ST_ALARM = 2'd2
  } state_t;

  // Expiry fires on the idle edge that would bring the count to TIMEOUT.
  localparam logic [3:0] TIMER_LAST = 4'(TIMEOUT - 1);
  localparam logic [2:0] FAIL_LIMIT = 3'(MAX_FAILS);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [1:0] fails_q, fails_d;
  logic       mismatch_q, mismatch_d;
  logic [3:0] timer_q, timer_d;
  logic       unlocked_q, unlocked_d;
  logic       alarm_q, alarm_d;

  logic [1:0] key_digit;
  logic       digit_eq;

  always_comb begin
    key_digit = 2'b00;
    case (idx_q)
      2'd0: key_digit = bus.key[1:0];
      2'd1: key_digit = bus.key[3:2];
      2'd2: key_digit = bus.key[5:4];
      2'd3: key_digit = bus.key[7:6];
      default: key_digit = 2'b00;
    endcase
    digit_eq = (bus.din[1] ~^ key_digit[1]) & (bus.din[0] ~^ key_digit[0]);
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    fails_d    = fails_q;
    mismatch_d = mismatch_q;
    timer_d    = timer_q;

    case (state_q)
      ST_ENTRY: begin
        if (bus.din_valid) begin
          // A digit always wins over a coincident timer expiry.
          timer_d = 4'd0;
          if (idx_q != 2'd3) begin
            idx_d      = idx_q + 2'd1;
            mismatch_d = mismatch_q | ~digit_eq;
          end else begin
            idx_d      = 2'd0;
            mismatch_d = 1'b0;
            if (!mismatch_q && digit_eq) begin
              state_d = ST_OPEN;
              fails_d = 2'd0;
            end else if (({1'b0, fails_q} + 3'd1) == FAIL_LIMIT) begin
              state_d = ST_ALARM;
              fails_d = FAIL_LIMIT[1:0];
            end else begin
              fails_d = fails_q + 2'd1;
            end
          end
        end else if (idx_q != 2'd0) begin
          if (timer_q == TIMER_LAST) begin
            idx_d      = 2'd0;
            mismatch_d = 1'b0;
            timer_d    = 4'd0;
          end else begin
            timer_d = timer_q + 4'd1;
          end
        end
      end
      ST_OPEN: begin
        if (bus.lock_cmd) begin
          state_d    = ST_ENTRY;
          idx_d      = 2'd0;
          mismatch_d = 1'b0;
          timer_d    = 4'd0;
        end
      end
      ST_ALARM: begin
        state_d = ST_ALARM;
      end
      default: begin
        state_d    = ST_ENTRY;
        idx_d      = 2'd0;
        mismatch_d = 1'b0;
        timer_d    = 4'd0;
      end
    endcase

    unlocked_d = (state_d == ST_OPEN);
    alarm_d    = (state_d == ST_ALARM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ENTRY;
      idx_q      <= 2'd0;
      fails_q    <= 2'd0;
      mismatch_q <= 1'b0;
      timer_q    <= 4'd0;
      unlocked_q <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      fails_q    <= fails_d;
      mismatch_q <= mismatch_d;
      timer_q    <= timer_d;
      unlocked_q <= unlocked_d;
      alarm_q    <= alarm_d;
    end
  end

  assign bus.unlocked = unlocked_q;
  assign bus.alarm    = alarm_q;
  assign bus.fails    = fails_q;
  assign bus.idx      = idx_q;

endmodule

// File: tb/tb_code_lock_fsm.sv
// tb_code_lock_fsm
//   Directed testbench for code_lock_fsm with default parameters
//   (TIMEOUT=15, MAX_FAILS=3). Inputs are driven 1 time unit after the
//   rising edge and outputs are read 1 time unit after the next edge.
module tb_code_lock_fsm;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  code_lock_if bus ();

  code_lock_fsm #(.TIMEOUT(15), .MAX_FAILS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] KEY = 8'b11_10_01_00;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic digit(input logic [1:0] d);
    bus.din       = d;
    bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
  endtask

  task automatic enter4(input logic [1:0] a, input logic [1:0] b,
                        input logic [1:0] c, input logic [1:0] d);
    digit(a);
    digit(b);
    digit(c);
    digit(d);
  endtask

  task automatic lock_pulse();
    bus.lock_cmd = 1'b1;
    tick();
    bus.lock_cmd = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.unlocked !== 1'b0) begin bad++; $display("FAIL reset_unlocked got=%b want=0", bus.unlocked); end
    total++; if (bus.alarm !== 1'b0) begin bad++; $display("FAIL reset_alarm got=%b want=0", bus.alarm); end
    total++; if (bus.fails !== 2'd0) begin bad++; $display("FAIL reset_fails got=%0d want=0", bus.fails); end
    total++; if (bus.idx !== 2'd0) begin bad++; $display("FAIL reset_idx got=%0d want=0", bus.idx); end
  endtask

  task automatic test_correct();
    logic [1:0] exp_idx [4];
    exp_idx = '{2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.unlocked !== 1'b0) begin bad++; $display("FAIL correct_early_unlock step=%0d got=%b want=0", i, bus.unlocked); end
      digit(2'(i));
      total++; if (bus.idx !== exp_idx[i]) begin bad++; $display("FAIL correct_idx step=%0d got=%0d want=%0d", i, bus.idx, exp_idx[i]); end
    end
    total++; if (bus.unlocked !== 1'b1) begin bad++; $display("FAIL correct_unlocked got=%b want=1", bus.unlocked); end
    total++; if (bus.fails !== 2'd0) begin bad++; $display("FAIL correct_fails got=%0d want=0", bus.fails); end
    // digits ignored while open
    digit(2'd0);
    total++; if (bus.idx !== 2'd0 || bus.unlocked !== 1'b1) begin bad++; $display("FAIL open_ignore_din idx=%0d unlocked=%b want idx=0 unlocked=1", bus.idx, bus.unlocked); end
    lock_pulse();
    total++; if (bus.unlocked !== 1'b0 || bus.idx !== 2'd0) begin bad++; $display("FAIL open_lock_cmd unlocked=%b idx=%0d want unlocked=0 idx=0", bus.unlocked, bus.idx); end
  endtask

  task automatic test_wrong3();
    do_reset();
    enter4(2'd0, 2'd1, 2'd2, 2'd2);
    total++; if (bus.fails !== 2'd1 || bus.alarm !== 1'b0 || bus.unlocked !== 1'b0) begin bad++; $display("FAIL wrong1 fails=%0d alarm=%b unlocked=%b want 1/0/0", bus.fails, bus.alarm, bus.unlocked); end
    enter4(2'd0, 2'd1, 2'd2, 2'd2);
    total++; if (bus.fails !== 2'd2 || bus.alarm !== 1'b0) begin bad++; $display("FAIL wrong2 fails=%0d alarm=%b want 2/0", bus.fails, bus.alarm); end
    enter4(2'd0, 2'd1, 2'd2, 2'd2);
    total++; if (bus.alarm !== 1'b1 || bus.fails !== 2'd3) begin bad++; $display("FAIL wrong3_alarm alarm=%b fails=%0d want 1/3", bus.alarm, bus.fails); end
    enter4(2'd0, 2'd1, 2'd2, 2'd3);
    total++; if (bus.alarm !== 1'b1 || bus.unlocked !== 1'b0) begin bad++; $display("FAIL alarm_absorb_digits alarm=%b unlocked=%b want 1/0", bus.alarm, bus.unlocked); end
    lock_pulse();
    total++; if (bus.alarm !== 1'b1) begin bad++; $display("FAIL alarm_absorb_lock got=%b want=1", bus.alarm); end
    do_reset();
    total++; if (bus.alarm !== 1'b0 || bus.fails !== 2'd0) begin bad++; $display("FAIL alarm_rst alarm=%b fails=%0d want 0/0", bus.alarm, bus.fails); end
  endtask

  task automatic test_sticky_mismatch();
    do_reset();
    enter4(2'd3, 2'd1, 2'd2, 2'd3);
    total++; if (bus.fails !== 2'd1 || bus.unlocked !== 1'b0) begin bad++; $display("FAIL sticky_first_digit fails=%0d unlocked=%b want 1/0", bus.fails, bus.unlocked); end
  endtask

  task automatic test_timeout();
    do_reset();
    digit(2'd0);
    repeat (10) tick();
    digit(2'd1);
    repeat (14) tick();
    total++; if (bus.idx !== 2'd2) begin bad++; $display("FAIL timeout_early got=%0d want=2", bus.idx); end
    tick();
    total++; if (bus.idx !== 2'd0 || bus.fails !== 2'd0) begin bad++; $display("FAIL timeout_expire idx=%0d fails=%0d want 0/0", bus.idx, bus.fails); end
    enter4(2'd0, 2'd1, 2'd2, 2'd3);
    total++; if (bus.unlocked !== 1'b1) begin bad++; $display("FAIL timeout_then_unlock got=%b want=1", bus.unlocked); end
  endtask

  task automatic test_expiry_digit();
    do_reset();
    digit(2'd0);
    digit(2'd1);
    repeat (14) tick();
    digit(2'd2);
    total++; if (bus.idx !== 2'd3) begin bad++; $display("FAIL expiry_digit_wins got=%0d want=3", bus.idx); end
    digit(2'd3);
    total++; if (bus.unlocked !== 1'b1) begin bad++; $display("FAIL expiry_digit_unlock got=%b want=1", bus.unlocked); end
  endtask

  task automatic test_lock_in_entry();
    do_reset();
    digit(2'd0);
    lock_pulse();
    total++; if (bus.idx !== 2'd1 || bus.unlocked !== 1'b0) begin bad++; $display("FAIL entry_lock_ignored idx=%0d unlocked=%b want 1/0", bus.idx, bus.unlocked); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    enter4(2'd0, 2'd1, 2'd2, 2'd2);
    enter4(2'd0, 2'd1, 2'd2, 2'd2);
    digit(2'd0);
    digit(2'd1);
    total++; if (bus.fails !== 2'd2 || bus.idx !== 2'd2) begin bad++; $display("FAIL mid_setup fails=%0d idx=%0d want 2/2", bus.fails, bus.idx); end
    do_reset();
    total++; if (bus.idx !== 2'd0 || bus.fails !== 2'd0 || bus.unlocked !== 1'b0 || bus.alarm !== 1'b0) begin bad++; $display("FAIL mid_reset idx=%0d fails=%0d unlocked=%b alarm=%b want 0/0/0/0", bus.idx, bus.fails, bus.unlocked, bus.alarm); end
    // reset wins over a digit that would complete the entry
    digit(2'd0); digit(2'd1); digit(2'd2);
    bus.din = 2'd3; bus.din_valid = 1'b1; rst = 1'b1;
    tick();
    bus.din_valid = 1'b0; rst = 1'b0;
    total++; if (bus.unlocked !== 1'b0 || bus.idx !== 2'd0) begin bad++; $display("FAIL rst_priority unlocked=%b idx=%0d want 0/0", bus.unlocked, bus.idx); end
  endtask

  task automatic test_fail_recovery();
    do_reset();
    enter4(2'd1, 2'd1, 2'd2, 2'd3);
    total++; if (bus.fails !== 2'd1) begin bad++; $display("FAIL recovery_fail got=%0d want=1", bus.fails); end
    enter4(2'd0, 2'd1, 2'd2, 2'd3);
    total++; if (bus.unlocked !== 1'b1 || bus.fails !== 2'd0) begin bad++; $display("FAIL recovery_unlock unlocked=%b fails=%0d want 1/0", bus.unlocked, bus.fails); end
  endtask

  task automatic test_key_change();
    do_reset();
    digit(2'd0);
    bus.key = 8'b11_10_01_11;
    digit(2'd1);
    digit(2'd2);
    digit(2'd3);
    total++; if (bus.unlocked !== 1'b1) begin bad++; $display("FAIL key_change_past got=%b want=1", bus.unlocked); end
    lock_pulse();
    bus.key = 8'b00_10_01_00;
    enter4(2'd0, 2'd1, 2'd2, 2'd3);
    total++; if (bus.unlocked !== 1'b0 || bus.fails !== 2'd1) begin bad++; $display("FAIL key_change_future unlocked=%b fails=%0d want 0/1", bus.unlocked, bus.fails); end
    bus.key = KEY;
  endtask

  initial begin
    bus.din       = 2'd0;
    bus.din_valid = 1'b0;
    bus.key       = KEY;
    bus.lock_cmd  = 1'b0;
    test_reset();
    test_correct();
    test_wrong3();
    test_sticky_mismatch();
    test_timeout();
    test_expiry_digit();
    test_lock_in_entry();
    test_reset_mid();
    test_fail_recovery();
    test_key_change();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
